// File: rtl/chronologic_pkg.sv
// Shared types, default latency bounds and the latency clamp for the chronologic arbiter.
package chronologic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        GRANT = 2'd2
    } state_t;

    localparam int MIN_LAT_DEF = 2;
    localparam int MAX_LAT_DEF = 5;

    // Pulls a requested latency into the supported [lo, hi] window.
    function automatic int clamp_delay(input int cfg, input int lo, input int hi);
        if (cfg < lo) return lo;
        if (cfg > hi) return hi;
        return cfg;
    endfunction

endpackage

// File: rtl/chronologic_if.sv
// Request/grant bundle between the masters (master modport) and the arbiter (slave modport).
interface chronologic_if
    import chronologic_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LAT_W   = 3
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // request is a level held by a master until it sees its single-cycle grant bit;
    // the arbiter never acknowledges a request any other way.
    logic [NUM_REQ-1:0] request;
    logic [LAT_W-1:0]   cfg_delay;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               busy;
    logic               req_drop_err;
    state_t             dbg_state;

    modport master (
        output request, cfg_delay,
        input  grant, grant_id, busy, req_drop_err, dbg_state
    );

    modport slave (
        input  request, cfg_delay,
        output grant, grant_id, busy, req_drop_err, dbg_state
    );

endinterface

// File: rtl/chronologic_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping around.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] request,
    input  logic [ID_W-1:0]    ptr,
    output logic               valid,
    output logic [NUM_REQ-1:0] onehot,
    output logic [ID_W-1:0]    idx
);

    int              j;
    logic [ID_W-1:0] jj;

    always_comb begin
        valid  = 1'b0;
        onehot = '0;
        idx    = '0;
        j      = 0;
        jj     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j  = (int'(ptr) + i) % NUM_REQ;
            jj = ID_W'(j);
            if (!valid && request[jj]) begin
                valid      = 1'b1;
                onehot[jj] = 1'b1;
                idx        = jj;
            end
        end
    end

endmodule

// File: rtl/chronologic.sv
// Bounded-latency round-robin arbiter: one grant exactly D cycles after selection,
// with D clamped to [MIN_LAT, MAX_LAT] and a pulse when a selected master withdraws.
module chronologic
    import chronologic_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int MIN_LAT = MIN_LAT_DEF,
    parameter int MAX_LAT = MAX_LAT_DEF,
    parameter int LAT_W   = 3
) (
    input  logic           clk,
    input  logic           rst,
    chronologic_if.slave   bus
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             state_q, state_n;
    logic [LAT_W-1:0]   cnt_q, cnt_n;
    logic [LAT_W-1:0]   d_q, d_n;
    logic [ID_W-1:0]    id_q, id_n;
    logic [ID_W-1:0]    ptr_q, ptr_n;
    logic [NUM_REQ-1:0] win_q, win_n;
    logic [NUM_REQ-1:0] grant_q, grant_n;
    logic               err_q, err_n;

    logic               pick_valid;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [ID_W-1:0]    pick_idx;
    logic [LAT_W-1:0]   d_sel;
    logic [ID_W-1:0]    ptr_after;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .request (bus.request),
        .ptr     (ptr_q),
        .valid   (pick_valid),
        .onehot  (pick_onehot),
        .idx     (pick_idx)
    );

    assign d_sel     = LAT_W'(clamp_delay(int'(bus.cfg_delay), MIN_LAT, MAX_LAT));
    assign ptr_after = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            d_q     <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            win_q   <= '0;
            grant_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            d_q     <= d_n;
            id_q    <= id_n;
            ptr_q   <= ptr_n;
            win_q   <= win_n;
            grant_q <= grant_n;
            err_q   <= err_n;
        end
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        d_n     = d_q;
        id_n    = id_q;
        ptr_n   = ptr_q;
        win_n   = win_q;
        grant_n = '0;
        err_n   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    id_n    = pick_idx;
                    win_n   = pick_onehot;
                    d_n     = d_sel;
                    cnt_n   = LAT_W'(1);
                    state_n = WAIT;
                end
            end
            WAIT: begin
                // Withdrawal wins over a grant due on the same edge; the pointer stays put.
                if ((bus.request & win_q) == '0) begin
                    err_n   = 1'b1;
                    cnt_n   = '0;
                    state_n = IDLE;
                end else if (cnt_q == d_q - LAT_W'(1)) begin
                    grant_n = win_q;
                    state_n = GRANT;
                end else begin
                    cnt_n = cnt_q + LAT_W'(1);
                end
            end
            GRANT: begin
                ptr_n   = ptr_after;
                cnt_n   = '0;
                state_n = IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    assign bus.grant        = grant_q;
    assign bus.grant_id     = id_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.req_drop_err = err_q;
    assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_chronologic.sv
// Bench for chronologic: vector table, random single-master latencies and hand-written
// corner sequences on a 4-master and a 1-master instance.
module tb_chronologic;
    import chronologic_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    chronologic_if #(.NUM_REQ(4), .LAT_W(3)) bus4 ();
    chronologic_if #(.NUM_REQ(1), .LAT_W(3)) bus1 ();

    chronologic #(.NUM_REQ(4), .MIN_LAT(2), .MAX_LAT(5), .LAT_W(3)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    chronologic #(.NUM_REQ(1), .MIN_LAT(2), .MAX_LAT(5), .LAT_W(3)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    logic [3:0] req_v = '0;
    logic [2:0] cfg_v = '0;
    logic       sel   = 1'b0;

    assign bus4.request   = sel ? 4'b0000 : req_v;
    assign bus1.request   = sel ? req_v[0:0] : 1'b0;
    assign bus4.cfg_delay = cfg_v;
    assign bus1.cfg_delay = cfg_v;

    logic [3:0] obs_grant;
    logic [1:0] obs_id;
    logic       obs_busy;
    logic       obs_err;
    assign obs_grant = sel ? {3'b000, bus1.grant} : bus4.grant;
    assign obs_id    = sel ? 2'(bus1.grant_id) : bus4.grant_id;
    assign obs_busy  = sel ? bus1.busy : bus4.busy;
    assign obs_err   = sel ? bus1.req_drop_err : bus4.req_drop_err;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [3:0] req;
        logic [2:0] cfg;
        int         exp_id;
        int         exp_lat;
    } vec_t;
    vec_t vecs[12];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int model_lat(input int c);
        return (c < 2) ? 2 : ((c > 5) ? 5 : c);
    endfunction

    task automatic drive(input logic [3:0] mask, input logic [2:0] cfg);
        @(negedge clk);
        req_v = req_v | mask;
        cfg_v = cfg;
    endtask

    // The next rising edge after the call is the selection edge E0.
    task automatic txn(input string name, input int exp_id, input int exp_lat, input int cfg_late);
        logic [7:0] e;
        int         lat;
        int         busy_ok;
        int         err_seen;
        exp_q.push_back({4'(exp_id), 4'(exp_lat)});
        lat      = 0;
        busy_ok  = 1;
        err_seen = 0;
        for (int k = 0; k < 8 && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (obs_err) err_seen = 1;
            if (!obs_busy) busy_ok = 0;
            if (obs_grant != 4'b0000) lat = k + 1;
            if (k == 0 && cfg_late >= 0) cfg_v = 3'(cfg_late);
        end
        e = exp_q.pop_front();
        check({name, "_seen"}, int'(lat != 0), 1);
        check({name, "_lat"}, lat, int'(e[3:0]));
        check({name, "_id"}, int'(obs_id), int'(e[7:4]));
        check({name, "_onehot"}, int'(obs_grant), 1 << e[7:4]);
        check({name, "_busy"}, busy_ok, 1);
        check({name, "_noerr"}, err_seen, 0);
        @(negedge clk);
        req_v = req_v & ~obs_grant;
        @(posedge clk);
        #1;
        check({name, "_grant_clr"}, int'(obs_grant), 0);
        check({name, "_busy_clr"}, int'(obs_busy), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        req_v = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [3:0] prev_g = '0;
    always @(posedge clk) begin
        #1;
        if (obs_grant != 4'b0000) begin
            checks++;
            if ($countones(obs_grant) != 1 || prev_g != 4'b0000) begin
                failures++;
                $display("FAIL grant_shape actual=%b previous=%b required=onehot_after_zero", obs_grant, prev_g);
            end
        end
        prev_g = obs_grant;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    int m;
    int c;
    int grant_seen;

    initial begin
        vecs[0]  = '{4'b0001, 3'd2, 0, 2};
        vecs[1]  = '{4'b0001, 3'd4, 0, 4};
        vecs[2]  = '{4'b0001, 3'd5, 0, 5};
        vecs[3]  = '{4'b0010, 3'd0, 1, 2};
        vecs[4]  = '{4'b1000, 3'd7, 3, 5};
        vecs[5]  = '{4'b0100, 3'd3, 2, 3};
        vecs[6]  = '{4'b1001, 3'd2, 3, 2};
        vecs[7]  = '{4'b0000, 3'd6, 0, 5};
        vecs[8]  = '{4'b1111, 3'd1, 1, 2};
        vecs[9]  = '{4'b0000, 3'd3, 2, 3};
        vecs[10] = '{4'b0000, 3'd4, 3, 4};
        vecs[11] = '{4'b0000, 3'd2, 0, 2};

        rst = 1'b1;
        sel = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_grant", int'(bus4.grant), 0);
        check("rst_id", int'(bus4.grant_id), 0);
        check("rst_busy", int'(bus4.busy), 0);
        check("rst_err", int'(bus4.req_drop_err), 0);
        check("rst_state", int'(bus4.dbg_state), int'(IDLE));
        check("rst_n1_grant", int'(bus1.grant), 0);
        check("rst_n1_busy", int'(bus1.busy), 0);

        drive(4'b0001, 3'd2);
        txn("n1_d2", 0, 2, -1);
        drive(4'b0001, 3'd7);
        txn("n1_d7", 0, 5, -1);
        @(negedge clk);
        sel = 1'b0;

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].req, vecs[i].cfg);
            txn($sformatf("vec%0d", i), vecs[i].exp_id, vecs[i].exp_lat, -1);
        end

        drive(4'b0001, 3'd2);
        txn("cfg_late", 0, 2, 5);

        for (int n = 0; n < 8; n++) begin
            m = $urandom_range(0, 3);
            c = $urandom_range(0, 7);
            drive(4'(1 << m), 3'(c));
            txn($sformatf("rand%0d", n), m, model_lat(c), -1);
        end

        do_reset();
        drive(4'b0101, 3'd2);
        txn("pair_m0", 0, 2, -1);
        txn("pair_m2", 2, 2, -1);
        drive(4'b1001, 3'd3);
        txn("ptr3_m3", 3, 3, -1);
        txn("ptr3_m0", 0, 3, -1);

        do_reset();
        drive(4'b0010, 3'd5);
        grant_seen = 0;
        @(posedge clk);
        #1;
        check("drop_busy_e0", int'(obs_busy), 1);
        @(posedge clk);
        #1;
        if (obs_grant != 4'b0000) grant_seen = 1;
        @(posedge clk);
        #1;
        if (obs_grant != 4'b0000) grant_seen = 1;
        check("drop_noerr_early", int'(obs_err), 0);
        @(negedge clk);
        req_v[1] = 1'b0;
        @(posedge clk);
        #1;
        check("drop_err", int'(obs_err), 1);
        check("drop_busy_clr", int'(obs_busy), 0);
        if (obs_grant != 4'b0000) grant_seen = 1;
        @(posedge clk);
        #1;
        check("drop_err_pulse", int'(obs_err), 0);
        if (obs_grant != 4'b0000) grant_seen = 1;
        check("drop_nogrant", grant_seen, 0);
        drive(4'b0101, 3'd2);
        txn("drop_ptr_m0", 0, 2, -1);
        txn("drop_ptr_m2", 2, 2, -1);

        drive(4'b0010, 3'd2);
        txn("pre_rst_m1", 1, 2, -1);
        drive(4'b1000, 3'd5);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_grant", int'(bus4.grant), 0);
        check("midrst_busy", int'(bus4.busy), 0);
        check("midrst_id", int'(bus4.grant_id), 0);
        check("midrst_err", int'(bus4.req_drop_err), 0);
        check("midrst_state", int'(bus4.dbg_state), int'(IDLE));
        @(negedge clk);
        rst   = 1'b0;
        req_v = '0;
        grant_seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            if (obs_grant != 4'b0000 || obs_err || obs_busy) grant_seen = 1;
        end
        check("midrst_quiet", grant_seen, 0);
        drive(4'b0101, 3'd2);
        txn("midrst_ptr_m0", 0, 2, -1);
        txn("midrst_ptr_m2", 2, 2, -1);

        check("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/chronologic.md
Name: chronologic

Overview:
- Bounded-latency request/grant arbiter for NUM_REQ masters.
- Each master raises a level request and holds it until granted.
- The arbiter selects one requester round-robin and issues a one-cycle grant exactly D cycles after selection, where D is a configurable value clamped to [MIN_LAT, MAX_LAT] (2..5).
- Sits between bus masters and a shared resource; also reports protocol errors (request withdrawn before grant).

Parameters:
- NUM_REQ, 4, number of requesting masters (>=1)
- MIN_LAT, 2, minimum request-to-grant latency in cycles
- MAX_LAT, 5, maximum request-to-grant latency in cycles
- LAT_W, 3, width of cfg_delay and the internal latency counter; must hold MAX_LAT

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- request  in  NUM_REQ  level request per master, held until granted
- cfg_delay  in  LAT_W  requested grant latency D; sampled at selection
- grant  out  NUM_REQ  one-hot, single-cycle grant, registered
- grant_id  out  $clog2(NUM_REQ) (min 1)  index of current/last selected master
- busy  out  1  high while a selection is pending (WAIT state)
- req_drop_err  out  1  one-cycle pulse: selected master dropped request before grant

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: grant=0, grant_id=0, busy=0, req_drop_err=0, rr pointer=0, state=IDLE, counter=0. Reset applied mid-WAIT aborts silently; no grant, no error.
- Clamp: D = MIN_LAT if cfg_delay<MIN_LAT; MAX_LAT if cfg_delay>MAX_LAT; otherwise cfg_delay. Latched at selection; later cfg_delay changes do not affect the pending grant.
- FSM states: IDLE, WAIT, GRANT.
- IDLE: at edge E0, if any request bit is high:
  - select the first set bit at or after the rr pointer (wrapping);
  - latch winner into grant_id, latch D, counter=1;
  - go to WAIT; busy=1 from E0.
- WAIT: counter increments each edge.
  - When counter==D-1, assert grant[winner] and go to GRANT, so grant is sampled high at exactly edge E0+D.
  - With D=2, grant is set at E0+1.
- GRANT: grant high for one cycle. At the next edge:
  - clear grant and busy;
  - rr pointer = winner+1 mod NUM_REQ;
  - return to IDLE.
- Next selection can occur no earlier than the edge after grant clears. A master still requesting then is re-selected only via round-robin order.
- Withdrawal: if request[winner] is sampled low in WAIT:
  - pulse req_drop_err for one cycle; no grant;
  - rr pointer unchanged; return to IDLE.
- Non-selected masters: requests are ignored while busy; they wait and have no latency guarantee until selected.
- Simultaneous requests: exactly one grant bit at a time; never two grants in consecutive cycles.
- Request asserted in the same cycle grant is high counts as a new request after return to IDLE.

Decomposition:
- Package chronologic_pkg:
  - state enum (IDLE/WAIT/GRANT);
  - default MIN_LAT/MAX_LAT constants;
  - clamp function for D.
- Sub-module rr_picker: combinational round-robin first-set-from-pointer selector (request vector + pointer -> one-hot + index).

Test Plan:
- NUM_REQ=1, cfg_delay=2, request high at E0 and held -> grant high at E0+2 only, busy high E0..E0+2, no error.
- cfg_delay=4, then 5 -> grant at E0+4 and E0+5 respectively; cfg_delay=0 -> grant at E0+2; cfg_delay=7 -> grant at E0+5.
- Masters 0 and 2 request together, pointer 0 -> master 0 granted first. Master 2 is granted at the selection after the return to IDLE; grant_id 0 then 2, pointer ends at 3.
- cfg_delay=5, request dropped at E0+3 -> req_drop_err pulse at E0+3, no grant, busy low next cycle.
- rst asserted at E0+2 during WAIT (D=5) -> all outputs 0 next edge, no grant, no error, pointer 0.
- cfg_delay changed from 2 to 5 at E0+1 -> grant still at E0+2.
